// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern source. It produces registered hs/vs/de, 24-bit RGB and a
// start-of-frame pulse. The counters stay at the origin while disabled or in reset.
module video_timing_gen #(
  parameter int unsigned H_WIDTH  = 1920,
  parameter int unsigned H_START  = 2008,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_TOTAL  = 2200,
  parameter int unsigned V_HEIGHT = 1080,
  parameter int unsigned V_START  = 1084,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_TOTAL  = 1125,
  parameter int unsigned KH       = 30,
  parameter int unsigned KV       = 30,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [1:0]  pattern_i,
  input  logic [23:0] solid_i,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic [23:0] data_o,
  output logic        sof_o
);

  localparam int unsigned HW   = $clog2(H_TOTAL + 1);
  localparam int unsigned VW   = $clog2(V_TOTAL + 1);
  localparam int unsigned BarW = H_WIDTH / 8;

  localparam logic [HW-1:0] HLast   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HActEnd = HW'(H_WIDTH);
  localparam logic [HW-1:0] HsBeg   = HW'(H_START);
  localparam logic [HW-1:0] HsEnd   = HW'(H_START + H_SYNC);
  localparam logic [HW-1:0] KhLast  = HW'(KH - 1);
  localparam logic [HW-1:0] BarLast = HW'(BarW - 1);
  localparam logic [VW-1:0] VLast   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VActEnd = VW'(V_HEIGHT);
  localparam logic [VW-1:0] VsBeg   = VW'(V_START);
  localparam logic [VW-1:0] VsEnd   = VW'(V_START + V_SYNC);
  localparam logic [VW-1:0] KvLast  = VW'(KV - 1);

  if (H_WIDTH >= H_START) begin : g_bad_h_start
    $error("video_timing_gen: H_WIDTH must be below H_START");
  end
  if (H_START + H_SYNC > H_TOTAL) begin : g_bad_h_total
    $error("video_timing_gen: H_START+H_SYNC exceeds H_TOTAL");
  end
  if (V_HEIGHT >= V_START) begin : g_bad_v_start
    $error("video_timing_gen: V_HEIGHT must be below V_START");
  end
  if (V_START + V_SYNC > V_TOTAL) begin : g_bad_v_total
    $error("video_timing_gen: V_START+V_SYNC exceeds V_TOTAL");
  end
  if (H_WIDTH < 8) begin : g_bad_h_width
    $error("video_timing_gen: H_WIDTH must be at least 8");
  end

  logic [HW-1:0] h_q, h_d, hx_q, hx_d, hb_q, hb_d, bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [VW-1:0] v_q, v_d, vy_q, vy_d, vb_q, vb_d;
  logic [1:0]    pat_q, pat_d, cur_pat;
  logic [23:0]   solid_q, solid_d, cur_solid;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d, sof_q, sof_d;
  logic [23:0]   data_q, data_d, pix;
  logic          origin, active, hsa, vsa;
  logic [7:0]    h8, v8;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Raster and block counters; the block and bar counters replace dividers on h and v.
  always_comb begin
    h_d       = h_q;
    hx_d      = hx_q;
    hb_d      = hb_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    v_d       = v_q;
    vy_d      = vy_q;
    vb_d      = vb_q;
    if (!en_i) begin
      h_d       = '0;
      hx_d      = '0;
      hb_d      = '0;
      bar_cnt_d = '0;
      bar_idx_d = '0;
      v_d       = '0;
      vy_d      = '0;
      vb_d      = '0;
    end else if (h_q == HLast) begin
      h_d       = '0;
      hx_d      = '0;
      hb_d      = '0;
      bar_cnt_d = '0;
      bar_idx_d = '0;
      if (v_q == VLast) begin
        v_d  = '0;
        vy_d = '0;
        vb_d = '0;
      end else begin
        v_d = v_q + 1'b1;
        if (vy_q == KvLast) begin
          vy_d = '0;
          vb_d = vb_q + 1'b1;
        end else begin
          vy_d = vy_q + 1'b1;
        end
      end
    end else begin
      h_d = h_q + 1'b1;
      if (hx_q == KhLast) begin
        hx_d = '0;
        hb_d = hb_q + 1'b1;
      end else begin
        hx_d = hx_q + 1'b1;
      end
      // The last bar holds its index so it absorbs the remainder of the line.
      if (bar_idx_q != 3'd7) begin
        if (bar_cnt_q == BarLast) begin
          bar_cnt_d = '0;
          bar_idx_d = bar_idx_q + 1'b1;
        end else begin
          bar_cnt_d = bar_cnt_q + 1'b1;
        end
      end
    end
  end

  // Decode of the current counter state; the origin pixel already uses the new latch value.
  always_comb begin
    origin    = (h_q == '0) && (v_q == '0);
    active    = (h_q < HActEnd) && (v_q < VActEnd);
    hsa       = (h_q >= HsBeg) && (h_q < HsEnd);
    vsa       = (v_q >= VsBeg) && (v_q < VsEnd);
    cur_pat   = origin ? pattern_i : pat_q;
    cur_solid = origin ? solid_i : solid_q;
    h8        = 8'(h_q);
    v8        = 8'(v_q);
    case (cur_pat)
      2'd0:    pix = cur_solid;
      2'd1:    pix = bar_colour(bar_idx_q);
      2'd2:    pix = (hb_q[0] ^ vb_q[0]) ? 24'h000000 : 24'hFFFFFF;
      default: pix = {h8, v8, 8'(h8 + v8)};
    endcase

    pat_d   = pat_q;
    solid_d = solid_q;
    if (!en_i || origin) begin
      pat_d   = pattern_i;
      solid_d = solid_i;
    end

    hs_d   = (en_i && hsa) ? HS_POL : ~HS_POL;
    vs_d   = (en_i && vsa) ? VS_POL : ~VS_POL;
    de_d   = en_i && active;
    sof_d  = en_i && origin;
    data_d = (en_i && active) ? pix : 24'h000000;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_q       <= '0;
      hx_q      <= '0;
      hb_q      <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      v_q       <= '0;
      vy_q      <= '0;
      vb_q      <= '0;
      pat_q     <= pattern_i;
      solid_q   <= solid_i;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      de_q      <= 1'b0;
      sof_q     <= 1'b0;
      data_q    <= 24'h000000;
    end else begin
      h_q       <= h_d;
      hx_q      <= hx_d;
      hb_q      <= hb_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      v_q       <= v_d;
      vy_q      <= vy_d;
      vb_q      <= vb_d;
      pat_q     <= pat_d;
      solid_q   <= solid_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      sof_q     <= sof_d;
      data_q    <= data_d;
    end
  end

  assign hs_o   = hs_q;
  assign vs_o   = vs_q;
  assign de_o   = de_q;
  assign data_o = data_q;
  assign sof_o  = sof_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a small raster (12x6 clocks) with 2x2 checker blocks, plus one instance
// with default 1080p timing for the wide-counter gradient and sync positions.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en;
  logic [1:0]  pattern;
  logic [23:0] solid;
  logic        hs, vs, de, sof;
  logic [23:0] data;

  logic        rst_b, en_b;
  logic [1:0]  pattern_b;
  logic [23:0] solid_b;
  logic        hs_b, vs_b, de_b, sof_b;
  logic [23:0] data_b;

  video_timing_gen #(
    .H_WIDTH(8), .H_START(10), .H_SYNC(1), .H_TOTAL(12),
    .V_HEIGHT(4), .V_START(5), .V_SYNC(1), .V_TOTAL(6),
    .KH(2), .KV(2), .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .pattern_i(pattern), .solid_i(solid),
    .hs_o(hs), .vs_o(vs), .de_o(de), .data_o(data), .sof_o(sof)
  );

  video_timing_gen u_big (
    .clk_i(clk), .rst_ni(rst_b), .en_i(en_b), .pattern_i(pattern_b), .solid_i(solid_b),
    .hs_o(hs_b), .vs_o(vs_b), .de_o(de_b), .data_o(data_b), .sof_o(sof_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  pat;
    int          k;      // clocks since the first enabled edge; k = v*12 + h
    logic        de, hs, vs, sof;
    logic [23:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] p, input int k, input logic d, input logic h,
                     input logic v, input logic s, input logic [23:0] px);
    vec_t e;
    e.pat = p; e.k = k; e.de = d; e.hs = h; e.vs = v; e.sof = s; e.data = px;
    vecs.push_back(e);
  endtask

  // Two reset clocks with en high; the next edge after return processes (0,0).
  task automatic do_reset(input logic [1:0] p);
    rst_n   = 1'b0;
    en      = 1'b1;
    pattern = p;
    step();
    step();
    check("reset_idle", {4'b0, de, hs, vs, sof, data}, 32'h0);
    rst_n = 1'b1;
  endtask

  int de_cnt, hs_cnt, hs_misplaced, vs_cnt, vs_misplaced, sof_cnt, px_bad;

  initial begin
    rst_n = 1'b0; en = 1'b0; pattern = 2'd0; solid = 24'h123456;
    rst_b = 1'b0; en_b = 1'b1; pattern_b = 2'd3; solid_b = 24'h0;

    // Solid
    add(0, 0,  1, 0, 0, 1, 24'h123456);
    add(0, 7,  1, 0, 0, 0, 24'h123456);
    add(0, 8,  0, 0, 0, 0, 24'h000000);
    add(0, 10, 0, 1, 0, 0, 24'h000000);
    add(0, 11, 0, 0, 0, 0, 24'h000000);
    add(0, 48, 0, 0, 0, 0, 24'h000000);
    add(0, 60, 0, 0, 1, 0, 24'h000000);
    add(0, 70, 0, 1, 1, 0, 24'h000000);
    add(0, 71, 0, 0, 1, 0, 24'h000000);
    // Colour bars, one pixel per bar on an 8-pixel line
    add(1, 0,  1, 0, 0, 1, 24'hFFFFFF);
    add(1, 1,  1, 0, 0, 0, 24'hFFFF00);
    add(1, 2,  1, 0, 0, 0, 24'h00FFFF);
    add(1, 3,  1, 0, 0, 0, 24'h00FF00);
    add(1, 4,  1, 0, 0, 0, 24'hFF00FF);
    add(1, 5,  1, 0, 0, 0, 24'hFF0000);
    add(1, 6,  1, 0, 0, 0, 24'h0000FF);
    add(1, 7,  1, 0, 0, 0, 24'h000000);
    add(1, 8,  0, 0, 0, 0, 24'h000000);
    add(1, 12, 1, 0, 0, 0, 24'hFFFFFF);
    // Checker 2x2
    add(2, 0,  1, 0, 0, 1, 24'hFFFFFF);
    add(2, 1,  1, 0, 0, 0, 24'hFFFFFF);
    add(2, 2,  1, 0, 0, 0, 24'h000000);
    add(2, 3,  1, 0, 0, 0, 24'h000000);
    add(2, 4,  1, 0, 0, 0, 24'hFFFFFF);
    add(2, 6,  1, 0, 0, 0, 24'h000000);
    add(2, 7,  1, 0, 0, 0, 24'h000000);
    add(2, 9,  0, 0, 0, 0, 24'h000000);
    add(2, 13, 1, 0, 0, 0, 24'hFFFFFF);
    add(2, 24, 1, 0, 0, 0, 24'h000000);
    add(2, 25, 1, 0, 0, 0, 24'h000000);
    add(2, 26, 1, 0, 0, 0, 24'hFFFFFF);
    add(2, 28, 1, 0, 0, 0, 24'h000000);
    add(2, 30, 1, 0, 0, 0, 24'hFFFFFF);
    add(2, 36, 1, 0, 0, 0, 24'h000000);
    // Gradient
    add(3, 0,  1, 0, 0, 1, 24'h000000);
    add(3, 21, 0, 0, 0, 0, 24'h000000);
    add(3, 27, 1, 0, 0, 0, 24'h030205);
    add(3, 43, 1, 0, 0, 0, 24'h07030A);

    for (int p = 0; p < 4; p++) begin
      solid = 24'h123456;
      do_reset(2'(p));
      de_cnt = 0; hs_cnt = 0; hs_misplaced = 0; vs_cnt = 0; vs_misplaced = 0;
      sof_cnt = 0; px_bad = 0;
      for (int k = 0; k < 72; k++) begin
        step();
        foreach (vecs[i]) begin
          if (vecs[i].pat == 2'(p) && vecs[i].k == k)
            check($sformatf("vec_p%0d_k%0d", p, k), {4'b0, de, hs, vs, sof, data},
                  {4'b0, vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].sof, vecs[i].data});
        end
        de_cnt  += int'(de);
        hs_cnt  += int'(hs);
        vs_cnt  += int'(vs);
        sof_cnt += int'(sof);
        if (hs && (k % 12) != 10) hs_misplaced++;
        if (vs != ((k / 12) == 5)) vs_misplaced++;
        if (!de && data !== 24'h0) px_bad++;
        if (p == 0 && de && data !== 24'h123456) px_bad++;
      end
      check($sformatf("de_count_p%0d", p), de_cnt, 32);
      check($sformatf("hs_count_p%0d", p), hs_cnt, 6);
      check($sformatf("hs_place_p%0d", p), hs_misplaced, 0);
      check($sformatf("vs_count_p%0d", p), vs_cnt, 12);
      check($sformatf("vs_place_p%0d", p), vs_misplaced, 0);
      check($sformatf("sof_count_p%0d", p), sof_cnt, 1);
      check($sformatf("pixels_p%0d", p), px_bad, 0);
      step();
      check($sformatf("sof_next_frame_p%0d", p), {de, sof}, 2'b11);
    end

    // Mid-frame pattern change takes effect only at the next frame
    solid = 24'h123456;
    do_reset(2'd0);
    for (int k = 0; k <= 96; k++) begin
      step();
      if (k == 20) begin
        pattern = 2'd2;
        solid   = 24'hABCDEF;
      end
      if (k == 24) check("switch_k24", data, 24'h123456);
      if (k == 30) check("switch_k30", data, 24'h123456);
      if (k == 72) check("switch_sof", {7'b0, sof, data}, {8'h01, 24'hFFFFFF});
      if (k == 74) check("switch_k74", data, 24'h000000);
      if (k == 96) check("switch_k96", data, 24'h000000);
    end

    // en_i dropped while the counters sit at (5,1)
    solid = 24'h123456;
    do_reset(2'd0);
    for (int k = 0; k <= 16; k++) step();
    check("pre_drop_de", {de, data}, {1'b1, 24'h123456});
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("en_off_%0d", i), {4'b0, de, hs, vs, sof, data}, 32'h0);
    end
    en = 1'b1;
    step();
    check("reen_first", {3'b0, de, sof, data}, {8'h03, 24'h123456});
    de_cnt = 1; hs_misplaced = 0;
    for (int k = 1; k < 72; k++) begin
      step();
      de_cnt += int'(de);
      if (hs != ((k % 12) == 10)) hs_misplaced++;
    end
    check("reen_de_count", de_cnt, 32);
    check("reen_hs_place", hs_misplaced, 0);
    step();
    check("reen_sof_next", sof, 1'b1);

    // Reset asserted during the hsync pulse
    do_reset(2'd0);
    for (int k = 0; k <= 10; k++) step();
    check("pre_rst_hs", hs, 1'b1);
    rst_n   = 1'b0;
    pattern = 2'd3;
    step();
    check("rst_mid_idle", {4'b0, de, hs, vs, sof, data}, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k <= 27; k++) begin
      step();
      if (k == 0)  check("rst_restart_sof", {3'b0, de, sof, data}, {8'h03, 24'h000000});
      if (k == 27) check("rst_restart_grad", {7'b0, de, data}, {8'h01, 24'h030205});
    end

    // Default 1080p timing
    rst_b = 1'b1;
    for (int k = 0; k <= 2052; k++) begin
      step();
      if (k == 0)    check("big_sof", {de_b, sof_b}, 2'b11);
      if (k == 300)  check("big_grad_300", {7'b0, de_b, data_b}, {8'h01, 24'h2C002C});
      if (k == 1919) check("big_grad_1919", {7'b0, de_b, data_b}, {8'h01, 24'h7F007F});
      if (k == 1920) check("big_blank", {7'b0, de_b, data_b}, 32'h0);
      if (k == 2007) check("big_hs_before", hs_b, 1'b0);
      if (k == 2008) check("big_hs_start", hs_b, 1'b1);
      if (k == 2051) check("big_hs_last", hs_b, 1'b1);
      if (k == 2052) check("big_hs_end", {vs_b, hs_b}, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
